// File: rtl/cbc_cipher_serializer.sv
// Output stage of the CBC PRESENT encipher: captures a ciphertext frame in one cycle,
// streams it one block per valid/ready transfer, and publishes the final block as the next IV.
module cbc_cipher_serializer #(
    parameter int NUM_BLOCKS = 8,
    parameter int BLOCK_W    = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              load,
    input  logic [NUM_BLOCKS*BLOCK_W-1:0]     ciphertext,
    output logic                              load_ready,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [BLOCK_W-1:0]                out_data,
    output logic [$clog2(NUM_BLOCKS)-1:0]     out_index,
    output logic                              out_last,
    output logic [BLOCK_W-1:0]                next_iv,
    output logic                              iv_valid
);

    localparam int IDX_W   = $clog2(NUM_BLOCKS);
    localparam int FRAME_W = NUM_BLOCKS * BLOCK_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 32'sd1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]         state_r;
    logic [FRAME_W-1:0] shadow_r;
    logic               xfer_s;
    logic [IDX_W-1:0]   next_idx_s;

    // Block 0 sits in the most significant slice of the frame.
    function automatic logic [BLOCK_W-1:0] block_at(input logic [FRAME_W-1:0] frame,
                                                    input logic [IDX_W-1:0]   idx);
        return frame[(NUM_BLOCKS - 32'sd1 - int'(idx)) * BLOCK_W +: BLOCK_W];
    endfunction

    // Handshake decode and index increment.
    always_comb begin
        xfer_s     = out_valid & out_ready;
        next_idx_s = out_index + IDX_W'(1'b1);
    end

    // Capture/stream state machine; every output is driven from a register here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            shadow_r   <= {FRAME_W{1'b0}};
            load_ready <= 1'b1;
            out_valid  <= 1'b0;
            out_data   <= {BLOCK_W{1'b0}};
            out_index  <= {IDX_W{1'b0}};
            out_last   <= 1'b0;
            next_iv    <= {BLOCK_W{1'b0}};
            iv_valid   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    iv_valid <= 1'b0;
                    if (load) begin
                        state_r    <= ST_SEND;
                        shadow_r   <= ciphertext;
                        load_ready <= 1'b0;
                        out_valid  <= 1'b1;
                        out_index  <= {IDX_W{1'b0}};
                        out_data   <= block_at(ciphertext, {IDX_W{1'b0}});
                        out_last   <= 1'b0;
                    end
                end
                ST_SEND: begin
                    iv_valid <= 1'b0;
                    if (xfer_s) begin
                        if (out_index == LAST_IDX) begin
                            // out_data keeps the last block; sinks qualify with out_valid.
                            state_r    <= ST_IDLE;
                            load_ready <= 1'b1;
                            out_valid  <= 1'b0;
                            out_index  <= {IDX_W{1'b0}};
                            out_last   <= 1'b0;
                            next_iv    <= block_at(shadow_r, LAST_IDX);
                            iv_valid   <= 1'b1;
                        end else begin
                            out_index <= next_idx_s;
                            out_data  <= block_at(shadow_r, next_idx_s);
                            out_last  <= (next_idx_s == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    load_ready <= 1'b1;
                    out_valid  <= 1'b0;
                    out_index  <= {IDX_W{1'b0}};
                    out_last   <= 1'b0;
                    iv_valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule
